// File: rtl/traffic_fsm_multi.sv
// traffic_fsm_multi
// Round-robin traffic-light sequencer for NUM_DIR approaches. Each approach
// gets a base green, an optional single sensor-driven extension and a yellow.
// At the end of every cycle a pending pedestrian request is served by a walk
// phase. Phase lengths come from the shared interval timer: this block selects
// the interval, fires a one-cycle start pulse on every state entry and advances
// on the timer's expired pulse.

module traffic_fsm_multi #(
   parameter int NUM_DIR   = 2,
   parameter int SKIP_IDLE = 0
) (
   input  logic                 clk,
   input  logic                 sys_reset,
   input  logic [NUM_DIR-1:0]   sensor_sync_in,
   input  logic                 walkRegister_status,
   input  logic                 prg_sync_in,
   input  logic                 expired,
   output logic                 walkRegister_reset,
   output logic [1:0]           interval_address,
   output logic                 start_timer,
   output logic [3*NUM_DIR:0]   light_signals
);

   localparam int LW = 3*NUM_DIR+1;

   typedef enum logic [2:0] {
      INIT,
      GRN_BASE,
      GRN_EXT,
      YEL,
      WALK
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      dir_q, dir_d;
   logic            enter_d;
   logic            startTimer_q;
   logic            walkReset_q;
   logic [1:0]      addr_q;
   logic [LW-1:0]   lights_q;

   logic            sensorAtDir;
   logic            nextFound;
   logic [1:0]      nextDir;
   logic            timerDone;

   // Lamp pattern for a given state and active approach: every approach red
   // except the active one during green/yellow, walk lamp only in WALK.
   function automatic logic [LW-1:0] lightsFor(input state_t s, input logic [1:0] d);
      logic [LW-1:0] l;
      l = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         l[3*i +: 3] = 3'b100;
         if (d == i[1:0]) begin
            if (s == GRN_BASE || s == GRN_EXT) begin
               l[3*i +: 3] = 3'b001;
            end else if (s == YEL) begin
               l[3*i +: 3] = 3'b010;
            end
         end
      end
      l[LW-1] = (s == WALK);
      return l;
   endfunction

   // Timer interval each state runs on; INIT parks the select at tBASE.
   function automatic logic [1:0] addrFor(input state_t s);
      logic [1:0] a;
      case (s)
         GRN_EXT: a = 2'd1;
         YEL:     a = 2'd2;
         WALK:    a = 2'd3;
         default: a = 2'd0;
      endcase
      return a;
   endfunction

   // Sensor of the approach currently holding green, found by scanning so the
   // direction register never indexes past the real sensor width.
   always_comb begin
      sensorAtDir = 1'b0;
      for (int i = 0; i < NUM_DIR; i++) begin
         if (dir_q == i[1:0]) begin
            sensorAtDir = sensor_sync_in[i];
         end
      end
   end

   // Successor approach after yellow. A descending scan leaves the lowest
   // qualifying index; with skipping disabled only dir+1 qualifies, and when
   // nothing qualifies the cycle has ended.
   always_comb begin
      nextFound = 1'b0;
      nextDir   = 2'd0;
      for (int i = NUM_DIR-1; i >= 1; i--) begin
         if (i > int'(dir_q)) begin
            if (SKIP_IDLE == 0) begin
               if (i == int'(dir_q) + 1) begin
                  nextFound = 1'b1;
                  nextDir   = i[1:0];
               end
            end else if (sensor_sync_in[i]) begin
               nextFound = 1'b1;
               nextDir   = i[1:0];
            end
         end
      end
   end

   // An expiry in the same cycle as our own start pulse belongs to the old
   // interval and must not end the phase we just started.
   assign timerDone = expired && !startTimer_q;

   // Next-state selection. enter_d marks every transition, including a
   // reprogram restart into the state we are already in, so the timer is
   // always re-armed on entry.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      enter_d = 1'b0;
      case (state_q)
         INIT: begin
            state_d = GRN_BASE;
            dir_d   = 2'd0;
            enter_d = 1'b1;
         end
         GRN_BASE: begin
            if (timerDone) begin
               state_d = sensorAtDir ? GRN_EXT : YEL;
               enter_d = 1'b1;
            end
         end
         GRN_EXT: begin
            if (timerDone) begin
               state_d = YEL;
               enter_d = 1'b1;
            end
         end
         YEL: begin
            if (timerDone) begin
               enter_d = 1'b1;
               if (nextFound) begin
                  state_d = GRN_BASE;
                  dir_d   = nextDir;
               end else if (walkRegister_status) begin
                  state_d = WALK;
                  dir_d   = 2'd0;
               end else begin
                  state_d = GRN_BASE;
                  dir_d   = 2'd0;
               end
            end
         end
         WALK: begin
            if (timerDone) begin
               state_d = GRN_BASE;
               dir_d   = 2'd0;
               enter_d = 1'b1;
            end
         end
         default: begin
            state_d = INIT;
            dir_d   = 2'd0;
         end
      endcase
      if (state_q != INIT && prg_sync_in) begin
         state_d = GRN_BASE;
         dir_d   = 2'd0;
         enter_d = 1'b1;
      end
   end

   // State, direction and every output registered together so lamps, interval
   // select and pulses all change on the same edge as the state itself.
   always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         state_q      <= INIT;
         dir_q        <= 2'd0;
         startTimer_q <= 1'b0;
         walkReset_q  <= 1'b0;
         addr_q       <= 2'd0;
         lights_q     <= lightsFor(INIT, 2'd0);
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         startTimer_q <= enter_d;
         walkReset_q  <= enter_d && (state_d == WALK);
         addr_q       <= addrFor(state_d);
         lights_q     <= lightsFor(state_d, dir_d);
      end
   end

   assign start_timer        = startTimer_q;
   assign walkRegister_reset = walkReset_q;
   assign interval_address   = addr_q;
   assign light_signals      = lights_q;

endmodule

// File: tb/tb_traffic_fsm_multi.sv
// tb_traffic_fsm_multi
// Directed bench for a three-approach sequencer, one instance without and one
// with idle-approach skipping. The bench plays the interval timer, pushes the
// expected outputs whenever it drives a stimulus step and pops/compares them
// after the clock edge that should produce them.

module tb_traffic_fsm_multi;

   logic       clk;
   logic       sys_reset;
   logic [2:0] sensor;
   logic       walk;
   logic       prg;
   logic       expired;

   logic       wrstA, startA, wrstB, startB;
   logic [1:0] addrA, addrB;
   logic [9:0] lightsA, lightsB;

   typedef struct {
      string      tag;
      logic [9:0] lights;
      logic [1:0] addr;
      logic       start;
      logic       wrst;
   } exp_t;

   exp_t expQ[$];
   exp_t cur;
   int   sel;
   int   total;
   int   bad;

   traffic_fsm_multi #(.NUM_DIR(3), .SKIP_IDLE(0)) dutA (
      .clk                 (clk),
      .sys_reset           (sys_reset),
      .sensor_sync_in      (sensor),
      .walkRegister_status (walk),
      .prg_sync_in         (prg),
      .expired             (expired),
      .walkRegister_reset  (wrstA),
      .interval_address    (addrA),
      .start_timer         (startA),
      .light_signals       (lightsA)
   );

   traffic_fsm_multi #(.NUM_DIR(3), .SKIP_IDLE(1)) dutB (
      .clk                 (clk),
      .sys_reset           (sys_reset),
      .sensor_sync_in      (sensor),
      .walkRegister_status (walk),
      .prg_sync_in         (prg),
      .expired             (expired),
      .walkRegister_reset  (wrstB),
      .interval_address    (addrB),
      .start_timer         (startB),
      .light_signals       (lightsB)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected lamp word: code 0 all red, 1 green on d, 2 yellow on d, 3 walk.
   function automatic logic [9:0] lamps(input int d, input int code);
      logic [9:0] l;
      l = 10'b0_100_100_100;
      if (code == 1) l[3*d +: 3] = 3'b001;
      if (code == 2) l[3*d +: 3] = 3'b010;
      if (code == 3) l[9] = 1'b1;
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput();
      exp_t       e;
      logic [9:0] oL;
      logic [1:0] oA;
      logic       oS, oW;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $error("FAIL scoreboard-empty got=%0d want=1", expQ.size());
      end else begin
         e  = expQ.pop_front();
         oL = (sel == 0) ? lightsA : lightsB;
         oA = (sel == 0) ? addrA   : addrB;
         oS = (sel == 0) ? startA  : startB;
         oW = (sel == 0) ? wrstA   : wrstB;
         assert (oL === e.lights) else begin
            bad++;
            $error("FAIL %s lights got=%b want=%b", e.tag, oL, e.lights);
         end
         total++;
         assert (oA === e.addr) else begin
            bad++;
            $error("FAIL %s addr got=%0d want=%0d", e.tag, oA, e.addr);
         end
         total++;
         assert (oS === e.start) else begin
            bad++;
            $error("FAIL %s start got=%b want=%b", e.tag, oS, e.start);
         end
         total++;
         assert (oW === e.wrst) else begin
            bad++;
            $error("FAIL %s wrst got=%b want=%b", e.tag, oW, e.wrst);
         end
      end
   endtask

   // Drive expired/prg for one edge and expect a fresh state entry.
   task automatic applyStimulus(input logic ex, input logic p, input string tag,
                                input logic [9:0] l, input logic [1:0] a, input logic wr);
      exp_t e;
      expired  = ex;
      prg      = p;
      e.tag    = tag;
      e.lights = l;
      e.addr   = a;
      e.start  = 1'b1;
      e.wrst   = wr;
      expQ.push_back(e);
      tick();
      expired  = 1'b0;
      prg      = 1'b0;
      checkOutput();
      cur       = e;
      cur.start = 1'b0;
      cur.wrst  = 1'b0;
      cur.tag   = {tag, "-hold"};
   endtask

   // Stay in the current state for n cycles with pulses low.
   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back(cur);
         tick();
         checkOutput();
      end
   endtask

   task automatic expectReset(input string tag);
      exp_t e;
      e.tag    = tag;
      e.lights = lamps(0, 0);
      e.addr   = 2'd0;
      e.start  = 1'b0;
      e.wrst   = 1'b0;
      expQ.push_back(e);
      checkOutput();
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      sel       = 0;
      sys_reset = 1'b1;
      sensor    = 3'b000;
      walk      = 1'b0;
      prg       = 1'b0;
      expired   = 1'b0;
      tick();
      tick();
      expectReset("reset");

      // Plain round-robin with no sensors; first edge after release enters G0.
      sys_reset = 1'b0;
      applyStimulus(1'b0, 1'b0, "G0", lamps(0, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y0", lamps(0, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "G1", lamps(1, 1), 2'd0, 1'b0);
      expired = 1'b1;
      hold(1);
      expired = 1'b0;
      hold(2);
      applyStimulus(1'b1, 1'b0, "Y1", lamps(1, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "G2", lamps(2, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y2", lamps(2, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "G0-wrap", lamps(0, 1), 2'd0, 1'b0);

      // Single extension on G0 despite a sensor that stays high.
      sensor = 3'b001;
      hold(3);
      applyStimulus(1'b1, 1'b0, "G0ext", lamps(0, 1), 2'd1, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y0-after-ext", lamps(0, 2), 2'd2, 1'b0);
      sensor = 3'b000;
      hold(3);
      applyStimulus(1'b1, 1'b0, "G1-walkreq", lamps(1, 1), 2'd0, 1'b0);
      walk = 1'b1;
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y1-walkreq", lamps(1, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "G2-walkreq", lamps(2, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y2-walkreq", lamps(2, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "WALK", lamps(0, 3), 2'd3, 1'b1);
      walk = 1'b0;
      hold(3);
      applyStimulus(1'b1, 1'b0, "G0-after-walk", lamps(0, 1), 2'd0, 1'b0);

      // Reprogram restarts even from G0, and beats a coincident expiry in Y1.
      hold(2);
      applyStimulus(1'b0, 1'b1, "G0-prg", lamps(0, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y0-p", lamps(0, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "G1-p", lamps(1, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "Y1-p", lamps(1, 2), 2'd2, 1'b0);
      hold(2);
      applyStimulus(1'b1, 1'b1, "G0-prg-vs-exp", lamps(0, 1), 2'd0, 1'b0);

      // Asynchronous reset landing inside the GRN_EXT entry cycle.
      sensor = 3'b001;
      hold(2);
      expired = 1'b1;
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e.tag    = "G0ext-entry";
         e.lights = lamps(0, 1);
         e.addr   = 2'd1;
         e.start  = 1'b1;
         e.wrst   = 1'b0;
         expQ.push_back(e);
         checkOutput();
      end
      #1 sys_reset = 1'b1;
      #1 expectReset("async-reset");
      @(negedge clk);
      expired   = 1'b0;
      sensor    = 3'b000;
      sys_reset = 1'b0;
      applyStimulus(1'b0, 1'b0, "G0-after-reset", lamps(0, 1), 2'd0, 1'b0);

      // Skipping instance: only approach 2 has traffic, approach 1 stays red.
      sel       = 1;
      sys_reset = 1'b1;
      tick();
      expectReset("reset-skip");
      sys_reset = 1'b0;
      sensor    = 3'b100;
      applyStimulus(1'b0, 1'b0, "S-G0", lamps(0, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "S-Y0", lamps(0, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "S-G2", lamps(2, 1), 2'd0, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "S-G2ext", lamps(2, 1), 2'd1, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "S-Y2", lamps(2, 2), 2'd2, 1'b0);
      hold(3);
      applyStimulus(1'b1, 1'b0, "S-G0-wrap", lamps(0, 1), 2'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_fsm_multi.md
Name: traffic_fsm_multi

Overview:
- Parametrised successor to the team's two-approach traffic-light FSM.
- Sequences green/yellow phases round-robin over NUM_DIR approaches, with per-approach sensor extension, optional skipping of idle approaches, and a pedestrian walk phase at the end of each cycle.
- Drives the shared interval timer through interval_address/start_timer and consumes its expired pulse. Sits between the input synchronisers/walk register and the light drivers.

Parameters:
- NUM_DIR, 2, number of approaches (2..4); direction 0 is the main street.
- SKIP_IDLE, 0, 1 = skip approaches 1..NUM_DIR-1 whose sensor bit is low when advancing.

Ports:
- clk  in  1  system clock
- sys_reset  in  1  asynchronous active-high reset
- sensor_sync_in  in  NUM_DIR  synchronised vehicle-present sensor per approach
- walkRegister_status  in  1  latched pedestrian walk request
- prg_sync_in  in  1  synchronised reprogram request; restarts the cycle
- expired  in  1  one-cycle pulse from interval timer
- walkRegister_reset  out  1  one-cycle pulse clearing the walk register
- interval_address  out  2  timer interval select: 0=tBASE, 1=tEXT, 2=tYEL, 3=tWALK
- start_timer  out  1  one-cycle timer start pulse
- light_signals  out  3*NUM_DIR+1  bits [3d+2:3d] = {R,Y,G} of approach d; MSB = walk lamp

Behaviour:
- Clock and reset: one clock clk. sys_reset is asynchronous, active-high.
- Reset values: state=INIT, dir=0, start_timer=0, walkRegister_reset=0, interval_address=0, light_signals = all approaches red, walk=0.
- States: INIT, GRN_BASE, GRN_EXT, YEL, WALK. Direction register dir ranges 0..NUM_DIR-1.
- INIT:
  - Unconditionally goes to GRN_BASE with dir=0 on the first clk edge after sys_reset deasserts.
- Entry to any non-INIT state:
  - start_timer=1 for exactly that first cycle.
  - interval_address is set that same cycle and held for the whole state: GRN_BASE=0, GRN_EXT=1, YEL=2, WALK=3.
- expired handling:
  - Ignored in the entry cycle, i.e. any cycle where start_timer=1.
  - All transitions occur on the clk edge where expired=1 is sampled.
- GRN_BASE: approach dir G, all others R.
  - On expired: if sensor_sync_in[dir]=1, go to GRN_EXT; else go to YEL.
- GRN_EXT: approach dir G. On expired, go to YEL. At most one extension per green.
- YEL: approach dir Y, others R. On expired, select the next approach:
  - SKIP_IDLE=0: next = dir+1.
  - SKIP_IDLE=1: next = lowest index > dir with sensor_sync_in set; if none, end of cycle.
  - If next exceeds NUM_DIR-1, it is end of cycle.
  - End of cycle: go to WALK if walkRegister_status=1, else go to GRN_BASE with dir=0.
  - Otherwise: go to GRN_BASE with dir=next.
- WALK:
  - All approaches R, walk lamp=1.
  - walkRegister_reset=1 for the entry cycle only.
  - On expired, go to GRN_BASE with dir=0.
- prg_sync_in=1 sampled in any non-INIT state:
  - Next state is GRN_BASE with dir=0 and a fresh start_timer pulse, even if already in GRN_BASE dir 0.
  - Takes priority over a simultaneous expired.
  - Sustained prg_sync_in re-restarts every cycle.
- Walk request arriving mid-cycle is held by the external register. It is honoured only at end of cycle and never shortens a phase.
- Light outputs are registered and change on the same edge as the state.
- Never more than one approach non-red. Y and G are never both set.
- sys_reset asserted mid-phase returns to INIT immediately and asynchronously. The output pulses drop at once.
- Width rule: light_signals width tracks NUM_DIR. Unused sensor bits do not exist.

Test Plan:
- NUM_DIR=3, no sensors, expired every 5 cycles → after reset: INIT, then G0 (addr 0, start pulse), Y0 (addr 2), G1, Y1, G2, Y2, then G0 again. Each state entry gives exactly one start_timer pulse.
- sensor_sync_in=3'b001 held during G0 → G0 base (addr 0), then G0 ext (addr 1), then Y0. Only one extension, even though the sensor stays high.
- SKIP_IDLE=1, sensor_sync_in=3'b100 → from Y0 jump straight to G2. Approach 1 never leaves red.
- walkRegister_status=1 pulsed during G1 → after Y2, WALK (all red, walk lamp=1, addr 3). walkRegister_reset pulses exactly 1 cycle at WALK entry. After expired, G0.
- prg_sync_in pulsed during Y1 coincident with expired → next state G0 with a start_timer pulse and addr 0; no advance to G2.
- sys_reset asserted mid-GRN_EXT (async, between edges) → outputs go immediately to all-red, start_timer=0. After release, G0 is entered on the first edge.
